// File: rtl/alu_shift_sequencer_if.sv
// Request/result bundle between the microsequencer and the rotate/shift sequencer.
interface alu_shift_sequencer_if;
   logic        start;
   logic [4:0]  alu_op;
   logic        size;
   logic [15:0] A;
   logic [7:0]  count;
   logic        cy_in;
   logic        busy;
   logic        done;
   logic [15:0] R;
   logic [5:0]  flags;
   logic [5:0]  flags_we;

   modport master (
      output start, alu_op, size, A, count, cy_in,
      input  busy, done, R, flags, flags_we
   );

   modport slave (
      input  start, alu_op, size, A, count, cy_in,
      output busy, done, R, flags, flags_we
   );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle rotate/shift unit: one single-bit step per clock on acc/cy,
// final result and flags registered on the way into FIN.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// STEP  | one bit of rotate/shift per cycle, n counts down
// FIN   | done=1, R/flags/flags_we valid (held until next result)
module alu_shift_sequencer #(
   parameter int CNT_BITS = 5
) (
   input logic                 clock,
   input logic                 reset,
   alu_shift_sequencer_if.slave bus
);

   localparam logic [4:0] ALUOP_ROL  = 5'h08;
   localparam logic [4:0] ALUOP_ROR  = 5'h09;
   localparam logic [4:0] ALUOP_ROLC = 5'h0A;
   localparam logic [4:0] ALUOP_RORC = 5'h0B;
   localparam logic [4:0] ALUOP_SHL  = 5'h0C;
   localparam logic [4:0] ALUOP_SHR  = 5'h0D;
   localparam logic [4:0] ALUOP_SHRA = 5'h0E;
   localparam logic [4:0] ALUOP_SHLA = 5'h0F;

   typedef enum logic [1:0] {IDLE, STEP, FIN} state_t;

   state_t              state, state_nxt;
   logic [4:0]          op;
   logic                size_q;
   logic [15:0]         acc;
   logic                cy;
   logic [CNT_BITS-1:0] n;
   logic                a_msb;
   logic [15:0]         r_q;
   logic [5:0]          flags_q;
   logic [5:0]          we_q;

   logic [15:0] step_acc;
   logic        step_cy;
   logic [5:0]  fin_flags;
   logic [5:0]  fin_we;
   logic        start_ok;
   logic        op_ok;
   logic        unused_count;

   // upper count bits are intentionally ignored (count is masked)
   assign unused_count = ^bus.count;

   // recognised opcode check on the incoming request
   always_comb begin
      op_ok = 1'b0;
      case (bus.alu_op)
         ALUOP_ROL, ALUOP_ROR, ALUOP_ROLC, ALUOP_RORC,
         ALUOP_SHL, ALUOP_SHR, ALUOP_SHRA, ALUOP_SHLA: op_ok = 1'b1;
         default: op_ok = 1'b0;
      endcase
      start_ok = op_ok && (bus.count[CNT_BITS-1:0] != '0);
   end

   // state register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state and status decode
   always_comb begin
      state_nxt = state;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = start_ok ? STEP : FIN;
         end
         STEP: begin
            bus.busy = 1'b1;
            if (n == CNT_BITS'(1)) state_nxt = FIN;
         end
         FIN: begin
            bus.busy  = 1'b1;
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // single-bit step; byte mode works on acc[7:0] and leaves acc[15:8] alone
   always_comb begin
      logic [15:0] w;
      logic [7:0]  b;
      logic        wc;
      logic        bc;
      w  = acc;
      b  = acc[7:0];
      wc = cy;
      bc = cy;
      case (op)
         ALUOP_ROL: begin
            w = {acc[14:0], acc[15]}; wc = acc[15];
            b = {acc[6:0], acc[7]};   bc = acc[7];
         end
         ALUOP_ROR: begin
            w = {acc[0], acc[15:1]};  wc = acc[0];
            b = {acc[0], acc[7:1]};   bc = acc[0];
         end
         ALUOP_ROLC: begin
            w = {acc[14:0], cy};      wc = acc[15];
            b = {acc[6:0], cy};       bc = acc[7];
         end
         ALUOP_RORC: begin
            w = {cy, acc[15:1]};      wc = acc[0];
            b = {cy, acc[7:1]};       bc = acc[0];
         end
         ALUOP_SHL, ALUOP_SHLA: begin
            w = {acc[14:0], 1'b0};    wc = acc[15];
            b = {acc[6:0], 1'b0};     bc = acc[7];
         end
         ALUOP_SHR: begin
            w = {1'b0, acc[15:1]};    wc = acc[0];
            b = {1'b0, acc[7:1]};     bc = acc[0];
         end
         ALUOP_SHRA: begin
            w = {acc[15], acc[15:1]}; wc = acc[0];
            b = {acc[7], acc[7:1]};   bc = acc[0];
         end
         default: ;
      endcase
      step_acc = size_q ? w : {acc[15:8], b};
      step_cy  = size_q ? wc : bc;
   end

   // flags from the post-step acc/cy, used on the last STEP cycle
   always_comb begin
      logic msb;
      logic msb1;
      logic zero;
      logic par;
      logic v;
      logic is_shift;
      msb      = size_q ? step_acc[15] : step_acc[7];
      msb1     = size_q ? step_acc[14] : step_acc[6];
      zero     = size_q ? (step_acc == 16'h0000) : (step_acc[7:0] == 8'h00);
      par      = ~^step_acc[7:0];
      v        = 1'b0;
      is_shift = 1'b0;
      case (op)
         ALUOP_ROL, ALUOP_ROLC:  v = msb ^ step_cy;
         ALUOP_ROR, ALUOP_RORC:  v = msb ^ msb1;
         ALUOP_SHL, ALUOP_SHLA: begin v = msb ^ step_cy; is_shift = 1'b1; end
         ALUOP_SHR:             begin v = a_msb;         is_shift = 1'b1; end
         ALUOP_SHRA:            begin v = 1'b0;          is_shift = 1'b1; end
         default: ;
      endcase
      fin_flags = {is_shift & zero, is_shift & msb, is_shift & par, v, step_cy, 1'b0};
      fin_we    = is_shift ? 6'b111110 : 6'b000110;
   end

   // operand capture, stepping and result registers
   always_ff @(posedge clock) begin
      if (reset) begin
         op      <= '0;
         size_q  <= 1'b0;
         acc     <= '0;
         cy      <= 1'b0;
         n       <= '0;
         a_msb   <= 1'b0;
         r_q     <= '0;
         flags_q <= '0;
         we_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op     <= bus.alu_op;
                  size_q <= bus.size;
                  acc    <= bus.A;
                  cy     <= bus.cy_in;
                  n      <= bus.count[CNT_BITS-1:0];
                  a_msb  <= bus.size ? bus.A[15] : bus.A[7];
                  if (!start_ok) begin
                     r_q     <= bus.A;
                     flags_q <= '0;
                     we_q    <= '0;
                  end
               end
            end
            STEP: begin
               acc <= step_acc;
               cy  <= step_cy;
               n   <= n - CNT_BITS'(1);
               if (n == CNT_BITS'(1)) begin
                  r_q     <= step_acc;
                  flags_q <= fin_flags;
                  we_q    <= fin_we;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.R        = r_q;
   assign bus.flags    = flags_q;
   assign bus.flags_we = we_q;

endmodule

// File: doc/alu_shift_sequencer.md
Name: alu_shift_sequencer

Overview:
- Multi-cycle controller for rotate and shift instructions with variable counts (CL or immediate).
- Performs one single-bit step per clock and computes the final flags, including ROLC and RORC through carry.
- Sits beside the combinational ALU in the execute stage; the microsequencer starts it and stalls on busy.
- Uses the ALU's alu_op encoding and flag vector layout.

Parameters:
- CNT_BITS, 5, number of low count bits used as the effective count (count masked to 0..31).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  request; accepted only when busy=0.
- alu_op  in  5  ALU op code; valid: ALUOP_ROL, ROR, ROLC, RORC, SHL, SHR, SHRA, SHLA (same as SHL).
- size  in  1  0=byte (bits 7:0), 1=word.
- A  in  16  operand, captured on accept.
- count  in  8  shift count, captured and masked to CNT_BITS.
- cy_in  in  1  current CY flag, captured on accept.
- busy  out  1  high from accept until the done cycle, inclusive.
- done  out  1  one-cycle pulse; result and flags are valid in this cycle and held until the next accept.
- R  out  16  result.
- flags  out  6  bits: 0=AC, 1=CY, 2=V, 3=P, 4=S, 5=Z.
- flags_we  out  6  mask of flags the core must write back.

Behaviour:
- Reset values: busy=0, done=0, R=0, flags=0, flags_we=0, state=IDLE. Reset mid-operation aborts immediately, with no done pulse.
- States: IDLE, STEP, FIN.
- IDLE: on start, latch op, size, A into acc, cy_in into cy, and n = count[CNT_BITS-1:0]. Set busy=1.
  - n=0 or unsupported op: go to FIN.
  - Otherwise go to STEP.
- start while busy=1 is ignored; no queueing.
- STEP: one bit per cycle on acc/cy, with msb=7 (byte) or 15 (word). Byte mode never alters acc[15:8].
  - ROL: cy=acc[msb]; acc rotated left.
  - ROR: cy=acc[0]; acc rotated right.
  - ROLC: {cy,acc} rotated left through cy.
  - RORC: {acc,cy} rotated right through cy.
  - SHL/SHLA: cy=acc[msb]; shift left, 0 in.
  - SHR: cy=acc[0]; shift right, 0 in at msb.
  - SHRA: cy=acc[0]; shift right, acc[msb] replicated.
  - Decrement n; when n reaches 0, go to FIN.
- FIN: done=1; R=acc; go to IDLE. busy drops the cycle after done.
- Latency: done asserted n+1 cycles after the accept edge (n=0: next cycle).
- Flags at FIN, computed from the final acc/cy:
  - CY=cy.
  - V: ROL/ROLC/SHL = acc[msb]^cy; ROR/RORC = acc[msb]^acc[msb-1]; SHR = original A[msb]; SHRA = 0. V is computed by this formula for every count.
  - Shifts only: S=acc[msb]; Z=(acc masked to size)==0; P=even parity of acc[7:0] (1 if even).
  - AC=0 and is never written.
  - flags_we: rotates 000110; shifts 111110.
  - n=0 or unsupported op: R=A, flags_we=0.

Test Plan:
1. ROL, size=0, A=0x0081, count=1 -> done 2 cycles after accept; R=0x0003, CY=1, V=1, flags_we=000110.
2. RORC, size=1, A=0x0001, cy_in=0, count=2 -> R=0x8000, CY=0, V=1; busy high 3 cycles.
3. SHRA, size=0, A=0x12F0, count=4 -> R=0x12FF, CY=0, V=0, S=1, Z=0, P=1, flags_we=111110.
4. SHL, size=1, A=0x4000, count=0x21 (masked to 1) -> R=0x8000, CY=0, V=1, S=1, Z=0, P=1; done 2 cycles after accept.
5. count=0 with A=0xBEEF, then start while busy during a count=5 op -> first: done next cycle, R=0xBEEF, flags_we=0; second start ignored, exactly one done.
6. SHR, size=1, A=0xFFFF, count=31, reset asserted on the 10th STEP cycle -> busy=0, done=0, R=0 the next cycle; a new start is accepted the following cycle.
